// File: rtl/debug_jtag_host.sv
// System-side initiator for the 2-bit-IR virtual JTAG port of the Nios II debug slave.
// One command = IR load plus one DR_WIDTH-bit shift on a divided tck; the captured tdo frame is returned.
module debug_jtag_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int P  = 2 * TCK_DIV;
    localparam int CW = $clog2(P);
    localparam int BW = $clog2(DR_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(TCK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP
    } state_t;

    state_t              state_reg;
    logic [CW-1:0]       cnt_reg;
    logic [CW-1:0]       cnt_inc;
    logic [BW-1:0]       bit_reg;
    logic [DR_WIDTH-1:0] tx_reg;
    logic [DR_WIDTH-1:0] rx_reg;

    assign cnt_inc = cnt_reg + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            busy           <= 1'b0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= '0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        state_reg <= UIR;
                        ir_in     <= cmd_ir;
                        tx_reg    <= cmd_data;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        vs_uir    <= 1'b1;
                        cnt_reg   <= '0;
                        tck       <= 1'b0;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        ir_in     <= '0;
                    end
                end

                default: begin
                    // tdo is taken on the clk cycle where tck has just risen
                    if (state_reg == SHIFT && cnt_reg == CNT_RISE) begin
                        rx_reg <= {tdo, rx_reg[DR_WIDTH-1:1]};
                    end

                    if (cnt_reg != CNT_LAST) begin
                        cnt_reg <= cnt_inc;
                        tck     <= (cnt_inc >= CNT_RISE);
                    end else begin
                        // End of a tck period: every state restarts at count 0 with tck low
                        cnt_reg <= '0;
                        tck     <= 1'b0;
                        case (state_reg)
                            UIR: begin
                                state_reg <= CDR;
                                vs_uir    <= 1'b0;
                                vs_cdr    <= 1'b1;
                            end
                            CDR: begin
                                state_reg <= SHIFT;
                                vs_cdr    <= 1'b0;
                                vs_sdr    <= 1'b1;
                                bit_reg   <= '0;
                                tdi       <= tx_reg[0];
                            end
                            SHIFT: begin
                                if (bit_reg == BIT_LAST) begin
                                    state_reg <= UDR;
                                    vs_sdr    <= 1'b0;
                                    vs_udr    <= 1'b1;
                                    tdi       <= 1'b0;
                                end else begin
                                    bit_reg <= bit_reg + BW'(1);
                                    tx_reg  <= tx_reg >> 1;
                                    tdi     <= tx_reg[1];
                                end
                            end
                            UDR: begin
                                state_reg      <= RTI;
                                vs_udr         <= 1'b0;
                                jtag_state_rti <= 1'b1;
                            end
                            RTI: begin
                                state_reg      <= RESP;
                                jtag_state_rti <= 1'b0;
                                rsp_valid      <= 1'b1;
                                rsp_data       <= rx_reg;
                            end
                            default: state_reg <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_jtag_host.sv
// Directed bench for debug_jtag_host: reset, loopback, capture order, TCK_DIV=1, backpressure, mid-shift reset.
module tb_debug_jtag_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    int          tests_run = 0;
    int          failures = 0;

    // DUT A: default parameters
    logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
    logic [1:0]  cmd_ir = '0, ir_in;
    logic [37:0] cmd_data = '0, rsp_data;
    logic        busy, tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, rti;

    // DUT B: TCK_DIV = 1
    logic        cmd_valid_b = 1'b0, cmd_ready_b, rsp_valid_b, rsp_ready_b = 1'b0;
    logic [1:0]  cmd_ir_b = '0, ir_in_b;
    logic [37:0] cmd_data_b = '0, rsp_data_b;
    logic        busy_b, tck_b, tdi_b, tdo_b, vs_uir_b, vs_cdr_b, vs_sdr_b, vs_udr_b, rti_b;

    debug_jtag_host dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(rti)
    );

    debug_jtag_host #(.TCK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_ir(cmd_ir_b), .cmd_data(cmd_data_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_data(rsp_data_b), .busy(busy_b), .tck(tck_b), .tdi(tdi_b), .tdo(tdo_b), .ir_in(ir_in_b),
        .vs_uir(vs_uir_b), .vs_cdr(vs_cdr_b), .vs_sdr(vs_sdr_b), .vs_udr(vs_udr_b), .jtag_state_rti(rti_b)
    );

    // Slave model: presents pattern bit k during tck period k of shift-DR, advancing on tck falling edges
    logic        loop_a = 1'b1;
    logic [37:0] pat_a = '0, pat_b = '0;
    logic [5:0]  k_a = '0, k_b = '0;
    logic        sdr_prev_a = 1'b0, tck_prev_a = 1'b0, sdr_prev_b = 1'b0, tck_prev_b = 1'b0;

    assign tdo   = loop_a ? tdi : pat_a[k_a];
    assign tdo_b = pat_b[k_b];

    always @(negedge clk) begin
        if (!vs_sdr) k_a <= '0;
        else if (sdr_prev_a && tck_prev_a && !tck) k_a <= k_a + 6'd1;
        sdr_prev_a <= vs_sdr;
        tck_prev_a <= tck;
        if (!vs_sdr_b) k_b <= '0;
        else if (sdr_prev_b && tck_prev_b && !tck_b) k_b <= k_b + 6'd1;
        sdr_prev_b <= vs_sdr_b;
        tck_prev_b <= tck_b;
    end

    int w_uir, w_cdr, w_sdr, w_udr, w_rti, ir_bad, multi;

    // Called #1 after the cmd handshake edge; counts edges until rsp_valid appears
    task automatic wait_rsp_a(input logic [1:0] ir, output int lat);
        int n;
        lat = 0;
        w_uir = 0; w_cdr = 0; w_sdr = 0; w_udr = 0; w_rti = 0; ir_bad = 0; multi = 0;
        while (!rsp_valid && lat < 1000) begin
            w_uir += int'(vs_uir); w_cdr += int'(vs_cdr); w_sdr += int'(vs_sdr);
            w_udr += int'(vs_udr); w_rti += int'(rti);
            n = int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(rti);
            if (n > 1) multi++;
            if (ir_in !== ir) ir_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (ir_in !== ir) ir_bad++;
    endtask

    task automatic run_cmd_a(input logic [1:0] ir, input logic [37:0] data, output int lat);
        cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp_a(ir, lat);
        $display("[TB] txn ir=%b data=%h rsp=%h lat=%0d", ir, data, rsp_data, lat);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({rsp_valid, busy, tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti} !== 11'd0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ctl=%b data=%h, want all 0",
                     {rsp_valid, busy, tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti}, rsp_data);
        end
        tests_run++;
        if (cmd_ready !== 1'b1 || cmd_ready_b !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b/%b, want 1/1", cmd_ready, cmd_ready_b);
        end
        reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (tck !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_tck_low: %0d bad idle cycles, want 0", bad);
        end
    endtask

    task automatic test_loopback();
        int lat;
        logic [37:0] d = 38'h3F_1234_5678;
        loop_a = 1'b1; rsp_ready = 1'b1;
        run_cmd_a(2'b10, d, lat);
        tests_run++;
        if (lat != 168) begin failures++; $display("FAIL loop_latency: got %0d, want 168", lat); end
        tests_run++;
        if (rsp_data !== d) begin failures++; $display("FAIL loop_data: got %h, want %h", rsp_data, d); end
        tests_run++;
        if (w_uir != 4 || w_cdr != 4 || w_udr != 4 || w_rti != 4) begin
            failures++;
            $display("FAIL loop_strobe_widths: uir=%0d cdr=%0d udr=%0d rti=%0d, want 4 each", w_uir, w_cdr, w_udr, w_rti);
        end
        tests_run++;
        if (w_sdr != 152) begin failures++; $display("FAIL loop_sdr_width: got %0d, want 152", w_sdr); end
        tests_run++;
        if (ir_bad != 0 || multi != 0) begin
            failures++;
            $display("FAIL loop_ir_onehot: ir_bad=%0d multi=%0d, want 0/0", ir_bad, multi);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || ir_in !== 2'b00 || busy !== 1'b0 || rsp_data !== d) begin
            failures++;
            $display("FAIL loop_after_pulse: valid=%b ready=%b ir=%b busy=%b data=%h, want 0 1 00 0 %h",
                     rsp_valid, cmd_ready, ir_in, busy, rsp_data, d);
        end
    endtask

    task automatic test_capture();
        int lat;
        logic [37:0] pats [2];
        pats[0] = 38'h00_0000_0001;
        pats[1] = 38'h20_0000_0003;
        loop_a = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pat_a = pats[i];
            run_cmd_a(2'b01, 38'h2A_5A5A_C3C3, lat);
            tests_run++;
            if (rsp_data !== pats[i] || lat != 168) begin
                failures++;
                $display("FAIL capture_%0d: got %h lat %0d, want %h lat 168", i, rsp_data, lat, pats[i]);
            end
            @(posedge clk); #1;
        end
        loop_a = 1'b1;
    endtask

    task automatic test_tck_div1();
        int lat;
        logic [37:0] pats [2];
        pats[0] = 38'h00_0000_0001;
        pats[1] = 38'h20_0000_0003;
        rsp_ready_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pat_b = pats[i];
            cmd_ir_b = 2'b11; cmd_data_b = 38'h0F_0000_FFFF; cmd_valid_b = 1'b1;
            @(posedge clk); #1;
            cmd_valid_b = 1'b0;
            lat = 0;
            while (!rsp_valid_b && lat < 1000) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("[TB] txn div1 ir=11 rsp=%h lat=%0d", rsp_data_b, lat);
            tests_run++;
            if (lat != 84) begin failures++; $display("FAIL div1_latency_%0d: got %0d, want 84", i, lat); end
            tests_run++;
            if (rsp_data_b !== pats[i]) begin
                failures++;
                $display("FAIL div1_data_%0d: got %h, want %h", i, rsp_data_b, pats[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat, bad;
        logic [37:0] d1 = 38'h2A_AAAA_0F0F;
        logic [37:0] d2 = 38'h05_A5A5_3C3C;
        loop_a = 1'b1; rsp_ready = 1'b0;
        run_cmd_a(2'b01, d1, lat);
        tests_run++;
        if (lat != 168 || rsp_data !== d1) begin
            failures++;
            $display("FAIL bp_first: got %h lat %0d, want %h lat 168", rsp_data, lat, d1);
        end
        cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_data = d2;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== d1 || cmd_ready !== 1'b0 || busy !== 1'b1 || ir_in !== 2'b01) bad++;
        end
        tests_run++;
        if (bad != 0) begin failures++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_handshake: valid=%b ready=%b busy=%b, want 0 1 0", rsp_valid, cmd_ready, busy);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || ir_in !== 2'b11) begin
            failures++;
            $display("FAIL bp_second_accept: busy=%b ready=%b ir=%b, want 1 0 11", busy, cmd_ready, ir_in);
        end
        rsp_ready = 1'b1;
        wait_rsp_a(2'b11, lat);
        $display("[TB] txn ir=11 data=%h rsp=%h lat=%0d", d2, rsp_data, lat);
        tests_run++;
        if (lat != 168 || rsp_data !== d2 || ir_bad != 0) begin
            failures++;
            $display("FAIL bp_second_rsp: got %h lat %0d ir_bad %0d, want %h lat 168 ir_bad 0", rsp_data, lat, ir_bad, d2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        int n, seen, lat;
        logic [37:0] d = 38'h15_5555_5555;
        loop_a = 1'b1; rsp_ready = 1'b1;
        cmd_ir = 2'b10; cmd_data = 38'h3A_BCDE_F012; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!vs_sdr && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (vs_sdr !== 1'b1) begin failures++; $display("FAIL mid_reach_shift: vs_sdr=%b, want 1", vs_sdr); end
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++;
        if ({vs_uir, vs_cdr, vs_sdr, vs_udr, rti, tck, busy, rsp_valid} !== 8'd0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_state: got %b ready=%b, want 00000000 ready=1",
                     {vs_uir, vs_cdr, vs_sdr, vs_udr, rti, tck, busy, rsp_valid}, cmd_ready);
        end
        seen = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin failures++; $display("FAIL mid_no_rsp: %0d active cycles, want 0", seen); end
        run_cmd_a(2'b10, d, lat);
        tests_run++;
        if (rsp_data !== d || lat != 168) begin
            failures++;
            $display("FAIL mid_followup: got %h lat %0d, want %h lat 168", rsp_data, lat, d);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback();
        test_capture();
        test_tck_div1();
        test_backpressure();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/debug_jtag_host.md
Name: debug_jtag_host

Overview:
- Clock-domain initiator that drives the 2-bit-IR virtual JTAG interface of the Nios II debug slave from the system side.
- Used for on-chip scripted debug and for simulation in place of the host cable.
- Accepts one command: IR value plus 38-bit DR frame.
- Sequences update-IR, capture-DR, shift-DR, update-DR and run-test-idle on a divided tck, captures tdo, and returns the captured frame as a response.

Parameters:
DR_WIDTH, 38, shift-DR frame length in bits (>=2)
IR_WIDTH, 2, ir_in width
TCK_DIV, 2, clk cycles per tck half-period (>=1); one tck period P = 2*TCK_DIV clk cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; cmd handshake when cmd_valid & cmd_ready
cmd_ir  in  IR_WIDTH  instruction to load
cmd_data  in  DR_WIDTH  frame to shift out, bit 0 first
rsp_valid  out  1  response available
rsp_ready  in  1  response accept
rsp_data  out  DR_WIDTH  captured tdo frame, bit 0 = first sampled
busy  out  1  high in every state except IDLE
tck  out  1  generated test clock
tdi  out  1  serial data to slave
tdo  in  1  serial data from slave
ir_in  out  IR_WIDTH  instruction to slave
vs_uir  out  1  virtual update-IR
vs_cdr  out  1  virtual capture-DR
vs_sdr  out  1  virtual shift-DR
vs_udr  out  1  virtual update-DR
jtag_state_rti  out  1  run-test-idle

Behaviour:
- Reset: synchronous, active-high, overrides everything.
  - State IDLE; cmd_ready=1.
  - All other outputs 0: rsp_valid, rsp_data, busy, tck, tdi, ir_in, vs_*, jtag_state_rti.
  - Reset mid-operation aborts the command; no response is produced. tck is low on the first cycle after reset.
- States: IDLE -> UIR -> CDR -> SHIFT -> UDR -> RTI -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1, tck=0.
  - On handshake: latch cmd_ir into ir_in, latch cmd_data into tx shift register, go to UIR, cmd_ready=0 next cycle.
- tck generation (non-IDLE, non-RESP states):
  - Phase counter 0..P-1. tck=0 for counts 0..TCK_DIV-1, tck=1 for counts TCK_DIV..P-1.
  - Every state starts at count 0 with tck low.
- UIR, CDR, UDR, RTI: each lasts exactly one tck period (P cycles). The matching strobe (vs_uir / vs_cdr / vs_udr / jtag_state_rti) is high for the whole state and low otherwise.
- SHIFT: lasts DR_WIDTH tck periods with vs_sdr high throughout.
  - Bit k (k=0..DR_WIDTH-1) of cmd_data is on tdi for all of period k; tdi changes only at count 0.
  - tdo is sampled on the clk cycle where tck goes 0->1 (count TCK_DIV).
  - The sample is shifted into rx register MSB with right shift, so after DR_WIDTH samples the first-sampled bit sits at bit 0.
  - tdi returns to 0 on leaving SHIFT.
- ir_in holds its value from UIR through RESP. It clears to 0 on return to IDLE.
- RESP:
  - rsp_valid=1 and rsp_data=rx register.
  - Both hold stable until rsp_ready. On the handshake cycle go to IDLE; cmd_ready=1 next cycle.
  - rsp_ready high in advance gives a 1-cycle rsp_valid pulse.
  - rsp_data keeps its last value after handshake until the next response.
- Latency:
  - rsp_valid rises exactly (DR_WIDTH+4)*P cycles after the cmd handshake cycle.
  - Defaults: 42*4 = 168 cycles.
  - Minimum command-to-command spacing is that latency plus 1 handshake cycle plus 1 IDLE cycle.
- Ignored inputs:
  - cmd_valid outside IDLE is ignored and the command is not queued.
  - tdo outside SHIFT is ignored.
  - rsp_ready outside RESP is ignored.
- Only one strobe of vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_state_rti is ever high at a time; all are low in IDLE and RESP.
- TCK_DIV=1 is legal: tck toggles every clk cycle.

Test Plan:
- Reset values: assert reset for 3 cycles -> all outputs 0 except cmd_ready=1; tck stays 0 while IDLE.
- Loopback: tdo tied to tdi, cmd_ir=2'b10, cmd_data=38'h3F_1234_5678, rsp_ready=1 -> rsp_valid exactly 168 cycles after handshake, 1-cycle pulse, rsp_data=38'h3F_1234_5678. Strobe widths: vs_uir, vs_cdr, vs_udr and jtag_state_rti each 4 cycles; vs_sdr 152 cycles. ir_in=2'b10 throughout.
- Capture ordering: tdo driven from a model returning 38'h00_0000_0001 LSB-first on tck rising edges -> rsp_data=38'h00_0000_0001. Variant with TCK_DIV=1: latency 84 cycles.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid and rsp_data stable for all 10 cycles, cmd_ready=0. A second cmd_valid during this window is not accepted; it is accepted 1 cycle after the rsp handshake.
- Reset mid-shift: assert reset 20 cycles into SHIFT -> next cycle all strobes 0, tck=0, busy=0, cmd_ready=1, no rsp_valid ever. A following loopback command with cmd_data=38'h15_5555_5555 returns the same value.
